eth_frame_seq: RTL
==================

ETH_FRAME_SEQ -- requirements
Module: eth_frame_seq

Interface
REQ-001 SHALL have parameter NSLOT, default 4, number of message slots (power of 2, >=2).
REQ-002 SHALL have parameter DEPTH, default 64, bytes per slot (power of 2, 2..1024).
REQ-003 SHALL have parameter INTERVAL, default 125000000, clocks between automatic frames (>=2).
REQ-004 SHALL have parameter IFG, default 12, minimum idle clocks between frames (>=1).
REQ-005 SHALL have ports: clk  in  1  sole clock (tx_clk domain); reset  in  1  synchronous, active-high.
REQ-006 SHALL have ports: enable  in  1  auto-send enable; trig  in  1  manual send request pulse; trig_slot  in  log2(NSLOT)  slot for trig.
REQ-007 SHALL have ports: wr_en  in  1; wr_addr  in  log2(NSLOT*DEPTH)  {slot,byte}; wr_data  in  8  message RAM write.
REQ-008 SHALL have ports: len_we  in  1; len_slot  in  log2(NSLOT); len_data  in  log2(DEPTH)+1  frame length in bytes, 0 = slot disabled.
REQ-009 SHALL have ports: tx_start  out  1; tx_valid  out  1; tx_data  out  8; tx_error  out  1; tx_ready  in  1  (to eth_rgmii_tx).
REQ-010 SHALL have ports: busy  out  1; frame_done  out  1  pulse; frame_count  out  16; drop_count  out  16.

Function
REQ-011 SHALL hold NSLOT*DEPTH x 8 message RAM, synchronous read (1-clock latency), single write port; writes land on the clock edge with wr_en=1.
REQ-012 SHALL hold one length register per slot; len_we updates it at that edge.
REQ-013 SHALL run interval counter 0..INTERVAL-1 while enable=1, generating an auto request when it reads INTERVAL-1 and wrapping to 0; counter held at 0 while enable=0.
REQ-014 SHALL assign auto requests to auto_slot, which advances by 1 modulo NSLOT after every auto request (accepted, pended or dropped).
REQ-015 SHALL give trig priority over an auto request in the same clock; the losing auto request SHALL count as dropped.
REQ-016 SHALL ignore any request whose slot length is 0 at request time (no pend, no drop count).
REQ-017 SHALL accept a request in IDLE immediately; in any other state store it in a single-entry pending register if empty, else drop it and increment drop_count.
REQ-018 SHALL implement states IDLE, LOAD, SEND, GAP; IDLE->LOAD on accepted or pending request (pending consumed first).
REQ-019 LOAD (1 clock): latch slot and length, issue RAM read of byte 0, pulse tx_start=1 for exactly this clock, busy=1.
REQ-020 SHALL present byte 0 with tx_valid=1 on the clock after LOAD and enter SEND.
REQ-021 In SEND, tx_data/tx_valid SHALL stay stable until tx_valid&tx_ready; each transfer advances index by 1, next byte valid on the following clock (1 bubble per byte permitted, none required).
REQ-022 After the transfer of byte length-1, tx_valid SHALL drop next clock, frame_done SHALL pulse 1 clock, frame_count SHALL increment (wrapping 16-bit), and state SHALL enter GAP.
REQ-023 GAP SHALL last exactly IFG clocks, then go to IDLE; busy=1 in LOAD/SEND/GAP, 0 in IDLE.
REQ-024 Length or RAM writes to the active slot mid-frame SHALL NOT change the latched length; RAM bytes not yet read SHALL reflect the new data.
REQ-025 drop_count SHALL saturate at 16'hFFFF; tx_error SHALL be constant 0.
REQ-026 Frame of length DEPTH SHALL send all DEPTH bytes; byte index SHALL not wrap into the next slot.

Reset
REQ-027 On reset=1 at a clock edge: state IDLE, tx_start=0, tx_valid=0, tx_data=0, frame_done=0, busy=0, pending empty, interval counter=0, auto_slot=0, frame_count=0, drop_count=0, all lengths=0; RAM contents unchanged.
REQ-028 Reset mid-frame SHALL drop tx_valid on the next clock with no further bytes or frame_done.

Verification
REQ-029 Load slot 1 bytes 0x10..0x13, length 4, tx_ready=1, trig slot 1 -> one tx_start pulse, bytes 10,11,12,13 in order, frame_done once, frame_count=1.
REQ-030 Same frame with tx_ready toggling every other clock -> identical byte sequence, tx_data stable while tx_valid&!tx_ready.
REQ-031 INTERVAL=20, enable=1, lengths 2 on all slots -> frames from slots 0,1,2,3,0 at counter wraps, spaced 20 clocks.
REQ-032 Three trigs during a frame -> second frame runs after IFG clocks, drop_count=1.
REQ-033 trig and auto request same clock in IDLE -> trig slot sent, drop_count=1, auto_slot advanced.
REQ-034 Assert reset at byte 2 of a 6-byte frame -> tx_valid=0 next clock, counters 0, no frame_done; trig with length 0 afterwards -> no tx_start.

Source files
------------

// File: rtl/eth_frame_seq.sv
// eth_frame_seq: sequences stored Ethernet frames from a slotted message RAM
// onto a valid/ready byte stream, on a periodic timer or a manual trigger.
module eth_frame_seq #(
   parameter int NSLOT    = 4,
   parameter int DEPTH    = 64,
   parameter int INTERVAL = 125000000,
   parameter int IFG      = 12,
   localparam int SW = $clog2(NSLOT),
   localparam int BW = $clog2(DEPTH),
   localparam int AW = SW + BW,
   localparam int LW = BW + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          enable,
   input  logic          trig,
   input  logic [SW-1:0] trig_slot,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [7:0]    wr_data,
   input  logic          len_we,
   input  logic [SW-1:0] len_slot,
   input  logic [LW-1:0] len_data,
   output logic          tx_start,
   output logic          tx_valid,
   output logic [7:0]    tx_data,
   output logic          tx_error,
   input  logic          tx_ready,
   output logic          busy,
   output logic          frame_done,
   output logic [15:0]   frame_count,
   output logic [15:0]   drop_count
);
   localparam int CW = $clog2(INTERVAL);
   localparam int GW = $clog2(IFG + 1);

   typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;

   state_t        state_q, state_d;
   logic [7:0]    mem [NSLOT*DEPTH];
   logic [7:0]    rd_q;
   logic [LW-1:0] len_q [NSLOT];
   logic [CW-1:0] int_q, int_d;
   logic [SW-1:0] auto_slot_q, auto_slot_d, pend_slot_q, pend_slot_d;
   logic [SW-1:0] cur_slot_q, cur_slot_d, req_slot, src_slot;
   logic          pend_v_q, pend_v_d, tx_valid_q, tx_valid_d, frame_done_q, frame_done_d;
   logic [LW-1:0] cur_len_q, cur_len_d;
   logic [BW-1:0] idx_q, idx_d, idx_n;
   logic [GW-1:0] gap_q, gap_d;
   logic [15:0]   frame_count_q, frame_count_d, drop_count_q, drop_count_d;
   logic          auto_req, req_v, lost, full_drop, rd_en;
   logic [16:0]   drop_sum;

   always_comb begin
      auto_req      = enable && int_q == CW'(INTERVAL - 1);
      int_d         = (!enable || auto_req) ? '0 : int_q + 1'b1;
      auto_slot_d   = auto_slot_q + SW'(auto_req);
      req_slot      = trig ? trig_slot : auto_slot_q;
      req_v         = (trig || auto_req) && len_q[req_slot] != '0;
      lost          = trig && auto_req && len_q[auto_slot_q] != '0;
      src_slot      = pend_v_q ? pend_slot_q : req_slot;
      full_drop     = req_v && state_q != IDLE && pend_v_q;
      // In IDLE the pending entry is consumed, so a new request can refill it
      pend_v_d      = state_q == IDLE ? pend_v_q && req_v : pend_v_q || req_v;
      pend_slot_d   = (req_v && (state_q == IDLE || !pend_v_q)) ? req_slot : pend_slot_q;
      drop_sum      = {1'b0, drop_count_q} + 17'(lost) + 17'(full_drop);
      drop_count_d  = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      idx_n         = state_q == LOAD ? '0 : idx_q + 1'b1;
      state_d       = state_q;
      cur_slot_d    = cur_slot_q;
      cur_len_d     = cur_len_q;
      idx_d         = idx_q;
      gap_d         = gap_q;
      tx_valid_d    = tx_valid_q;
      frame_done_d  = 1'b0;
      frame_count_d = frame_count_q;
      rd_en         = 1'b0;
      case (state_q)
         IDLE: if ((pend_v_q || req_v) && len_q[src_slot] != '0) begin
            state_d    = LOAD;
            cur_slot_d = src_slot;
            cur_len_d  = len_q[src_slot];
         end
         LOAD: begin
            rd_en      = 1'b1;
            idx_d      = idx_n;
            tx_valid_d = 1'b1;
            state_d    = SEND;
         end
         SEND: if (tx_valid_q && tx_ready) begin
            if ({1'b0, idx_q} == cur_len_q - 1'b1) begin
               tx_valid_d    = 1'b0;
               frame_done_d  = 1'b1;
               frame_count_d = frame_count_q + 1'b1;
               gap_d         = '0;
               state_d       = GAP;
            end else begin
               rd_en = 1'b1;
               idx_d = idx_n;
            end
         end
         default: begin
            gap_d = gap_q + 1'b1;
            if (gap_q == GW'(IFG - 1)) state_d = IDLE;
         end
      endcase
   end

   // RAM read register only moves on a read, which holds tx_data through stalls
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_q <= mem[{cur_slot_q, idx_n}];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         int_q         <= '0;
         auto_slot_q   <= '0;
         pend_v_q      <= 1'b0;
         pend_slot_q   <= '0;
         cur_slot_q    <= '0;
         cur_len_q     <= '0;
         idx_q         <= '0;
         gap_q         <= '0;
         tx_valid_q    <= 1'b0;
         frame_done_q  <= 1'b0;
         frame_count_q <= '0;
         drop_count_q  <= '0;
         for (int i = 0; i < NSLOT; i++) len_q[i] <= '0;
      end else begin
         state_q       <= state_d;
         int_q         <= int_d;
         auto_slot_q   <= auto_slot_d;
         pend_v_q      <= pend_v_d;
         pend_slot_q   <= pend_slot_d;
         cur_slot_q    <= cur_slot_d;
         cur_len_q     <= cur_len_d;
         idx_q         <= idx_d;
         gap_q         <= gap_d;
         tx_valid_q    <= tx_valid_d;
         frame_done_q  <= frame_done_d;
         frame_count_q <= frame_count_d;
         drop_count_q  <= drop_count_d;
         if (len_we) len_q[len_slot] <= len_data > LW'(DEPTH) ? LW'(DEPTH) : len_data;
      end
   end

   assign tx_start    = state_q == LOAD;
   assign tx_valid    = tx_valid_q;
   assign tx_data     = tx_valid_q ? rd_q : 8'h00;
   assign tx_error    = 1'b0;
   assign busy        = state_q != IDLE;
   assign frame_done  = frame_done_q;
   assign frame_count = frame_count_q;
   assign drop_count  = drop_count_q;
endmodule
